mxreg_write_arbiter: RTL and testbench

Round-robin write-port arbiter for the 16-entry register bank.
- Shares the bank's single load port (`load_addr`, `load_en`, `data_line`) between `NREQ` requesters (ALU writeback, memory unit, fetch/INSP update, debug).
- Validates each write address against the load-decoder address map.
- Registers the winning write into one output stage, so the bank always sees glitch-free, single-cycle load strobes.

---
 rtl/mxregs_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/mxreg_write_arbiter.sv | 80 ++++++++
 tb/tb_mxreg_write_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mxregs_pkg.sv
// Shared constants and address-map helpers for the register bank load port.
// The valid set mirrors the load decoder: 0x00-0x13, 0x16 and 0x80.
package mxregs_pkg;

   localparam logic [7:0] ADDR_A       = 8'h00;
   localparam logic [7:0] ADDR_FLAGS_A = 8'h10;
   localparam logic [7:0] ADDR_FLAGS_D = 8'h13;
   localparam logic [7:0] ADDR_INSP_NF = 8'h16;
   localparam logic [7:0] ADDR_R2_INSP = 8'h80;

   localparam int FLAGS_IDX = 7;

   function automatic logic addr_valid(input logic [7:0] a);
      return (a <= ADDR_FLAGS_D) || (a == ADDR_INSP_NF) || (a == ADDR_R2_INSP);
   endfunction

   function automatic logic addr_has_flags(input logic [7:0] a);
      return (a >= ADDR_FLAGS_A) && (a <= ADDR_FLAGS_D);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant generator; the winner is the first requester at or after
// rr_ptr with wrap-around, and rr_ptr moves one past the winner on a transfer.
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            stall,
   output logic [NREQ-1:0] gnt,
   output logic            fire
);

   localparam int PW = $clog2(NREQ);

   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] rr_ptr_nxt;
   logic          found;

   // Upper pass covers [rr_ptr, NREQ-1]; lower pass supplies the wrap-around.
   always_comb begin
      gnt        = '0;
      rr_ptr_nxt = rr_ptr;
      found      = 1'b0;
      if (!stall) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i >= int'(rr_ptr))) begin
               gnt[i]     = 1'b1;
               found      = 1'b1;
               rr_ptr_nxt = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
               gnt[i]     = 1'b1;
               found      = 1'b1;
               rr_ptr_nxt = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
         end
      end
   end

   assign fire = found;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rr_ptr <= '0;
      else      rr_ptr <= rr_ptr_nxt;
   end

endmodule

// File: rtl/mxreg_write_arbiter.sv
// Shares the register bank load port between NREQ writers: arbitrates, checks
// the address map and registers the winning write into a single output stage.
module mxreg_write_arbiter
   import mxregs_pkg::*;
#(
   parameter int WORD_LENGTH = 8,
   parameter int DEPTH       = 16,
   parameter int NREQ        = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NREQ-1:0]                  req,
   input  logic [NREQ-1:0][7:0]             req_addr,
   input  logic [NREQ-1:0][WORD_LENGTH-1:0] req_data,
   input  logic [NREQ-1:0][WORD_LENGTH-1:0] req_flags,
   output logic [NREQ-1:0]                  gnt,
   input  logic                             stall,
   output logic                             load_en,
   output logic [7:0]                       load_addr,
   output logic [DEPTH-1:0][WORD_LENGTH-1:0] data_line,
   output logic                             err,
   output logic [7:0]                       err_cnt
);

   logic                   fire;
   logic [7:0]             sel_addr;
   logic [WORD_LENGTH-1:0] sel_data;
   logic [WORD_LENGTH-1:0] sel_flags;
   logic                   addr_ok;
   logic                   has_flags;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .stall (stall),
      .gnt   (gnt),
      .fire  (fire)
   );

   // gnt is one-hot, so an AND-OR mux picks the winner's payload.
   always_comb begin
      sel_addr  = '0;
      sel_data  = '0;
      sel_flags = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_addr  = sel_addr  | req_addr[i];
            sel_data  = sel_data  | req_data[i];
            sel_flags = sel_flags | req_flags[i];
         end
      end
   end

   assign addr_ok   = addr_valid(sel_addr);
   assign has_flags = addr_has_flags(sel_addr);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_en   <= 1'b0;
         load_addr <= ADDR_A;
         data_line <= '0;
         err       <= 1'b0;
         err_cnt   <= '0;
      end else begin
         load_en <= fire && addr_ok;
         err     <= fire && !addr_ok;
         if (fire && addr_ok) begin
            load_addr <= sel_addr;
            for (int l = 0; l < DEPTH; l++) begin
               data_line[l] <= (l == FLAGS_IDX && has_flags) ? sel_flags : sel_data;
            end
         end
         if (fire && !addr_ok && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_mxreg_write_arbiter.sv
// Directed bench for mxreg_write_arbiter with a reference model feeding a
// per-cycle scoreboard of expected registered outputs.
module tb_mxreg_write_arbiter;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              stall = 1'b0;
   logic [3:0]        req = '0;
   logic [3:0]        gnt;
   logic [3:0][7:0]   req_addr = '0;
   logic [3:0][7:0]   req_data = '0;
   logic [3:0][7:0]   req_flags = '0;
   logic              load_en;
   logic [7:0]        load_addr;
   logic [15:0][7:0]  data_line;
   logic              err;
   logic [7:0]        err_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic         en;
      logic [7:0]   addr;
      logic [127:0] line;
      logic         e;
      logic [7:0]   cnt;
   } exp_t;

   exp_t sb[$];

   logic [1:0]      m_ptr;
   logic [7:0]      m_addr;
   logic [7:0]      m_cnt;
   logic [127:0]    m_line;
   logic [3:0]      p_req;
   logic [3:0]      p_gnt;
   logic [3:0][7:0] p_addr, p_data, p_flags;
   logic [3:0]      g_seen;

   mxreg_write_arbiter #(.WORD_LENGTH(8), .DEPTH(16), .NREQ(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_flags (req_flags),
      .gnt       (gnt),
      .stall     (stall),
      .load_en   (load_en),
      .load_addr (load_addr),
      .data_line (data_line),
      .err       (err),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   function automatic bit b_valid(input logic [7:0] a);
      return (a < 8'h14) || (a == 8'h16) || (a == 8'h80);
   endfunction

   function automatic logic [127:0] lanes(input logic [7:0] d, input logic [7:0] f, input bit use_f);
      logic [15:0][7:0] v;
      for (int l = 0; l < 16; l++) v[l] = (l == 7 && use_f) ? f : d;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr  = '0;
      m_addr = '0;
      m_cnt  = '0;
      m_line = '0;
      p_req  = '0;
      p_gnt  = '0;
   endtask

   // One bus cycle: drive at the falling edge, check gnt, push the model's
   // expected register state, then pop and compare just after the rising edge.
   task automatic cyc(input logic [3:0] r, input logic s);
      exp_t       e;
      logic [3:0] eg;
      logic [1:0] idx;
      logic [1:0] wi;
      bit         won;
      req   = r;
      stall = s;
      #1;
      for (int i = 0; i < 4; i++) begin
         if (p_req[i] && !p_gnt[i] && req[i])
            chk("req_stable", 128'({req_addr[i], req_data[i], req_flags[i]}),
                128'({p_addr[i], p_data[i], p_flags[i]}));
      end
      eg  = '0;
      wi  = '0;
      won = 1'b0;
      if (!s) begin
         for (int k = 0; k < 4; k++) begin
            idx = m_ptr + 2'(k);
            if (!won && r[idx]) begin
               won     = 1'b1;
               wi      = idx;
               eg[idx] = 1'b1;
            end
         end
      end
      g_seen = gnt;
      chk("gnt", 128'(gnt), 128'(eg));
      e.en = 1'b0;
      e.e  = 1'b0;
      if (won) begin
         m_ptr = wi + 2'd1;
         if (b_valid(req_addr[wi])) begin
            e.en   = 1'b1;
            m_addr = req_addr[wi];
            m_line = lanes(req_data[wi], req_flags[wi],
                           (req_addr[wi] >= 8'h10) && (req_addr[wi] <= 8'h13));
         end else begin
            e.e = 1'b1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
         end
      end
      e.addr = m_addr;
      e.line = m_line;
      e.cnt  = m_cnt;
      sb.push_back(e);
      p_req   = req;
      p_gnt   = gnt;
      p_addr  = req_addr;
      p_data  = req_data;
      p_flags = req_flags;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("load_en",   128'(load_en),   128'(e.en));
      chk("load_addr", 128'(load_addr), 128'(e.addr));
      chk("data_line", data_line,       e.line);
      chk("err",       128'(err),       128'(e.e));
      chk("err_cnt",   128'(err_cnt),   128'(e.cnt));
      @(negedge clk);
   endtask

   logic [7:0] btbl [6];

   initial begin
      model_reset();
      #1 rst = 1'b0;
      #1;
      chk("rst_load_en",   128'(load_en),   128'(1'b0));
      chk("rst_load_addr", 128'(load_addr), 128'(8'h00));
      chk("rst_data_line", data_line,       128'(0));
      chk("rst_err",       128'(err),       128'(1'b0));
      chk("rst_err_cnt",   128'(err_cnt),   128'(8'h00));
      chk("rst_gnt",       128'(gnt),       128'(4'b0000));

      // first grant immediately after reset release
      @(negedge clk);
      rst         = 1'b1;
      req_addr[0] = 8'h01;
      req_data[0] = 8'h5A;
      cyc(4'b0001, 1'b0);
      chk("t1_gnt",  128'(g_seen),    128'(4'b0001));
      chk("t1_en",   128'(load_en),   128'(1'b1));
      chk("t1_addr", 128'(load_addr), 128'(8'h01));
      chk("t1_line", data_line,       {16{8'h5A}});

      // park the pointer at 0 so the fairness run starts from requester 0
      req_addr[3] = 8'h03;
      req_data[3] = 8'h44;
      cyc(4'b1000, 1'b0);

      req_addr = {8'h03, 8'h02, 8'h01, 8'h00};
      req_data = {8'h43, 8'h32, 8'h21, 8'h10};
      for (int c = 0; c < 8; c++) begin
         cyc(4'b1111, 1'b0);
         chk("t2_order",   128'(g_seen),  128'(4'(4'b0001 << (c % 4))));
         chk("t2_load_en", 128'(load_en), 128'(1'b1));
      end
      cyc(4'b0000, 1'b0);
      chk("idle_load_en", 128'(load_en), 128'(1'b0));

      // FLAGS lane only for 0x10-0x13
      req_addr[2]  = 8'h12;
      req_data[2]  = 8'h33;
      req_flags[2] = 8'hC1;
      cyc(4'b0100, 1'b0);
      chk("t3_lane7", 128'(data_line[7]), 128'(8'hC1));
      chk("t3_lane0", 128'(data_line[0]), 128'(8'h33));
      req_addr[2] = 8'h02;
      cyc(4'b0100, 1'b0);
      chk("t3_lane7_plain", 128'(data_line[7]), 128'(8'h33));

      // invalid address handshake and error counter saturation
      req_addr[1] = 8'h14;
      req_data[1] = 8'hEE;
      cyc(4'b0010, 1'b0);
      chk("t4_gnt",     128'(g_seen),  128'(4'b0010));
      chk("t4_en",      128'(load_en), 128'(1'b0));
      chk("t4_err",     128'(err),     128'(1'b1));
      chk("t4_cnt",     128'(err_cnt), 128'(8'h01));
      chk("t4_hold",    128'(load_addr), 128'(8'h02));
      for (int n = 0; n < 300; n++) cyc(4'b0010, 1'b0);
      chk("t4_cnt_sat", 128'(err_cnt), 128'(8'hFF));

      // stall: registered strobe survives, no grants, then 1 before 2
      req_addr[0] = 8'h05;
      req_data[0] = 8'h66;
      cyc(4'b0001, 1'b0);
      req_addr[1] = 8'h16;
      req_data[1] = 8'h77;
      req_addr[2] = 8'h80;
      req_data[2] = 8'h88;
      stall = 1'b1;
      req   = 4'b0110;
      #1;
      chk("t5_load_en_kept", 128'(load_en), 128'(1'b1));
      for (int n = 0; n < 3; n++) begin
         cyc(4'b0110, 1'b1);
         chk("t5_stall_gnt", 128'(g_seen),  128'(4'b0000));
         chk("t5_stall_en",  128'(load_en), 128'(1'b0));
      end
      cyc(4'b0110, 1'b0);
      chk("t5_first",  128'(g_seen),    128'(4'b0010));
      chk("t5_addr16", 128'(load_addr), 128'(8'h16));
      cyc(4'b0110, 1'b0);
      chk("t5_second", 128'(g_seen),    128'(4'b0100));
      chk("t5_addr80", 128'(load_addr), 128'(8'h80));

      // address map edges from requester 3
      btbl = '{8'h13, 8'h15, 8'h17, 8'h7F, 8'h81, 8'hFF};
      req_flags[3] = 8'h5C;
      for (int j = 0; j < 6; j++) begin
         req_addr[3] = btbl[j];
         req_data[3] = 8'(8'hA0 + j);
         cyc(4'b1000, 1'b0);
      end

      // asynchronous reset while a load strobe is on the bus
      req_addr[0] = 8'h04;
      req_data[0] = 8'h99;
      cyc(4'b0001, 1'b0);
      chk("t6_pre_en", 128'(load_en), 128'(1'b1));
      rst = 1'b0;
      #1;
      chk("t6_en",   128'(load_en),   128'(1'b0));
      chk("t6_addr", 128'(load_addr), 128'(8'h00));
      chk("t6_line", data_line,       128'(0));
      chk("t6_cnt",  128'(err_cnt),   128'(8'h00));
      chk("t6_err",  128'(err),       128'(1'b0));
      model_reset();
      @(posedge clk);
      #1;
      chk("t6_no_write_en",   128'(load_en), 128'(1'b0));
      chk("t6_no_write_line", data_line,     128'(0));
      @(negedge clk);
      rst = 1'b1;
      cyc(4'b1111, 1'b0);
      chk("t6_ptr_reset", 128'(g_seen), 128'(4'b0001));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
